// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter
//   Round-robin arbiter that hands a 4-digit seven-segment display to one of two
//   requesters and runs a brightness envelope for each service:
//   fade in (0 -> MAX), hold at MAX, fade out (MAX -> 0), then completion ack.
//   Brightness changes once per step tick (every STEP_CYCLES clocks).
//
// Ports
//   clk          system clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   req[1:0]     level-sensitive display requests, bit i = requester i
//   data0/data1  requester digit values, nibble k -> digit k (k=0 rightmost)
//   dp0/dp1      requester decimal points, bit k -> digit k
//   gnt[1:0]     one-hot grant, high for the whole service
//   ack[1:0]     one-cycle completion pulse
//   busy         high whenever the arbiter is not idle
//   hex0..hex3   latched digit values for the display multiplexer
//   dp_out       latched decimal points
//   pwm_control  brightness level, 0 (dark) .. 2^PWM_RESOLUTION (full on)
module sseg_display_arbiter #(
  parameter int unsigned PWM_RESOLUTION = 4,
  parameter int unsigned STEP_CYCLES    = 1_000_000,
  parameter int unsigned HOLD_STEPS     = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                req,
  input  logic [15:0]               data0,
  input  logic [15:0]               data1,
  input  logic [3:0]                dp0,
  input  logic [3:0]                dp1,
  output logic [1:0]                gnt,
  output logic [1:0]                ack,
  output logic                      busy,
  output logic [3:0]                hex0,
  output logic [3:0]                hex1,
  output logic [3:0]                hex2,
  output logic [3:0]                hex3,
  output logic [3:0]                dp_out,
  output logic [PWM_RESOLUTION:0]   pwm_control
);

  localparam int unsigned PwmW  = PWM_RESOLUTION + 1;
  localparam int unsigned CntW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;

  localparam logic [PwmW-1:0]  PwmMax   = {1'b1, {PWM_RESOLUTION{1'b0}}};
  localparam logic [PwmW-1:0]  PwmTop   = PwmMax - PwmW'(1);
  localparam logic [PwmW-1:0]  PwmOne   = PwmW'(1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(STEP_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFadeIn,
    StHold,
    StFadeOut
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;
  logic [HoldW-1:0] hold_q,  hold_d;
  logic [PwmW-1:0]  pwm_q,   pwm_d;
  logic [1:0]       gnt_q,   gnt_d;
  logic [1:0]       ack_q,   ack_d;
  logic             busy_q,  busy_d;
  logic [15:0]      hex_q,   hex_d;
  logic [3:0]       dp_q,    dp_d;
  logic             last_q,  last_d;  // index of the requester served last

  logic tick;
  logic owner_req;
  logic pick;

  assign tick      = (cnt_q == CntLast);
  // gnt_q is one-hot while busy, so this is the granted requester's own request.
  assign owner_req = |(req & gnt_q);
  // Contention goes to the requester not served last; otherwise whoever asks.
  assign pick      = (req == 2'b11) ? ~last_q : req[1];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|req) state_d = StFadeIn;
      end
      StFadeIn: begin
        if (!owner_req) begin
          // Nothing lit yet: nothing to fade, finish straight away.
          state_d = (pwm_q == '0) ? StIdle : StFadeOut;
        end else if (tick && (pwm_q == PwmTop)) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (!owner_req || (tick && (hold_q == HoldLast))) state_d = StFadeOut;
      end
      StFadeOut: begin
        // Requests are ignored here; the fade always runs to completion.
        if (tick && (pwm_q <= PwmOne)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    pwm_d  = pwm_q;
    gnt_d  = gnt_q;
    ack_d  = 2'b00;
    busy_d = (state_d != StIdle);
    hex_d  = hex_q;
    dp_d   = dp_q;
    last_d = last_q;

    // Step counter restarts on every state change and is parked at 0 in idle.
    if ((state_d != state_q) || (state_q == StIdle) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (state_d != StHold) begin
      hold_d = '0;
    end else if ((state_q == StHold) && tick) begin
      hold_d = hold_q + HoldW'(1);
    end

    unique case (state_q)
      StIdle: begin
        pwm_d = '0;
        if (|req) begin
          gnt_d  = pick ? 2'b10 : 2'b01;
          last_d = pick;
          hex_d  = pick ? data1 : data0;
          dp_d   = pick ? dp1 : dp0;
        end
      end
      StFadeIn: begin
        if (owner_req && tick && (pwm_q != PwmMax)) pwm_d = pwm_q + PwmOne;
      end
      StHold: begin
        pwm_d = PwmMax;
      end
      StFadeOut: begin
        if (tick && (pwm_q != '0)) pwm_d = pwm_q - PwmOne;
      end
      default: pwm_d = '0;
    endcase

    if ((state_q != StIdle) && (state_d == StIdle)) begin
      ack_d = gnt_q;
      gnt_d = 2'b00;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      hold_q <= '0;
      pwm_q  <= '0;
      gnt_q  <= 2'b00;
      ack_q  <= 2'b00;
      busy_q <= 1'b0;
      hex_q  <= 16'h0000;
      dp_q   <= 4'h0;
      last_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      pwm_q  <= pwm_d;
      gnt_q  <= gnt_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      hex_q  <= hex_d;
      dp_q   <= dp_d;
      last_q <= last_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign hex0        = hex_q[3:0];
  assign hex1        = hex_q[7:4];
  assign hex2        = hex_q[11:8];
  assign hex3        = hex_q[15:12];
  assign dp_out      = dp_q;
  assign pwm_control = pwm_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Bench for sseg_display_arbiter with STEP_CYCLES=4, HOLD_STEPS=2, PWM_RESOLUTION=4.
// A phase/level model predicts every output each cycle; directed scenarios add
// literal expectations for latencies, arbitration order, aborts and reset.
module tb_sseg_display_arbiter;

  localparam int Res  = 4;
  localparam int Step = 4;
  localparam int Hold = 2;
  localparam int Max  = 16;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req;
  logic [15:0] data0, data1;
  logic [3:0]  dp0, dp1;
  logic [1:0]  gnt, ack;
  logic        busy;
  logic [3:0]  hex0, hex1, hex2, hex3, dp_out;
  logic [Res:0] pwm_control;

  int n_checks = 0;
  int n_fail   = 0;

  sseg_display_arbiter #(
    .PWM_RESOLUTION(Res),
    .STEP_CYCLES   (Step),
    .HOLD_STEPS    (Hold)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .dp0        (dp0),
    .dp1        (dp1),
    .gnt        (gnt),
    .ack        (ack),
    .busy       (busy),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .dp_out     (dp_out),
    .pwm_control(pwm_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 fade in, 2 hold, 3 fade out.
  int          m_phase = 0;
  int          m_lvl   = 0;
  int          m_cyc   = 0;
  int          m_held  = 0;
  bit          m_last  = 1'b1;
  bit          m_own   = 1'b0;
  logic [15:0] m_hex   = 16'h0;
  logic [3:0]  m_dp    = 4'h0;
  logic [1:0]  m_ack   = 2'b00;

  always @(posedge clk or negedge reset_n) begin : model
    int p, l, c, h;
    bit own, last;
    logic [15:0] hx;
    logic [3:0] dp;
    logic [1:0] a;
    if (!reset_n) begin
      m_phase <= 0; m_lvl <= 0; m_cyc <= 0; m_held <= 0;
      m_last <= 1'b1; m_own <= 1'b0; m_hex <= 16'h0; m_dp <= 4'h0; m_ack <= 2'b00;
    end else begin
      p = m_phase; l = m_lvl; c = m_cyc; h = m_held;
      own = m_own; last = m_last; hx = m_hex; dp = m_dp; a = 2'b00;
      case (p)
        0: if (req != 2'b00) begin
          if (req[0] && req[1]) own = (last == 1'b0);
          else own = req[1];
          last = own;
          hx = own ? data1 : data0;
          dp = own ? dp1 : dp0;
          p = 1; l = 0; c = 0;
        end
        1: if (!req[own]) begin
          c = 0;
          if (l == 0) begin p = 0; a[own] = 1'b1; end
          else p = 3;
        end else begin
          c++;
          if (c == Step) begin
            c = 0; l++;
            if (l == Max) begin p = 2; h = 0; end
          end
        end
        2: if (!req[own]) begin
          p = 3; c = 0;
        end else begin
          c++;
          if (c == Step) begin
            c = 0; h++;
            if (h == Hold) p = 3;
          end
        end
        default: begin
          c++;
          if (c == Step) begin
            c = 0; l--;
            if (l == 0) begin p = 0; a[own] = 1'b1; end
          end
        end
      endcase
      m_phase <= p; m_lvl <= l; m_cyc <= c; m_held <= h;
      m_own <= own; m_last <= last; m_hex <= hx; m_dp <= dp; m_ack <= a;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [1:0] eg;
    eg = (m_phase != 0) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    check("cyc_gnt", gnt, eg);
    check("cyc_ack", ack, m_ack);
    check("cyc_busy", busy, m_phase != 0);
    check("cyc_pwm", pwm_control, (m_phase == 2) ? Max : m_lvl);
    check("cyc_hex", {hex3, hex2, hex1, hex0}, m_hex);
    check("cyc_dp", dp_out, m_dp);
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_pwm(input int lvl, input int budget, input string name, output int n);
    n = 0;
    while (pwm_control != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, pwm_control, lvl);
  endtask

  task automatic wait_ack(input logic [1:0] mask, input int budget, input string name,
                          output int n);
    n = 0;
    while (ack != mask && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, ack, mask);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 reset_n = 1'b0;
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset_n = 1'b1;
    req = 2'b00;
    data0 = 16'h1234; dp0 = 4'b0101;
    data1 = 16'hABCD; dp1 = 4'b1010;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_pwm", pwm_control, 0);
    check("rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
    check("rst_busy", busy, 1'b0);
    #3 reset_n = 1'b1;

    // Single service timing
    @(negedge clk); req = 2'b01;
    @(negedge clk);
    check("t1_gnt", gnt, 2'b01);
    check("t1_hex", {hex3, hex2, hex1, hex0}, 16'h1234);
    check("t1_dp", dp_out, 4'b0101);
    wait_pwm(16, 200, "t1_reach_max", n);
    check("t1_rise_cycles", n, 64);
    wait_pwm(15, 200, "t1_first_dim", n);
    check("t1_hold_cycles", n, 12);
    wait_ack(2'b01, 200, "t1_ack", n);
    check("t1_fall_cycles", n, 60);
    check("t1_ack_pwm", pwm_control, 0);
    req = 2'b00;
    @(negedge clk);
    check("t1_ack_once", ack, 2'b00);
    check("t1_idle_hex", {hex3, hex2, hex1, hex0}, 16'h1234);

    // Round robin after reset, then abort at level 0
    pulse_reset();
    req = 2'b11;
    @(negedge clk);
    check("t2_first", gnt, 2'b01);
    wait_ack(2'b01, 300, "t2_ack0", n);
    @(negedge clk);
    check("t2_second", gnt, 2'b10);
    check("t2_hex1", {hex3, hex2, hex1, hex0}, 16'hABCD);
    check("t2_dp1", dp_out, 4'b1010);
    wait_ack(2'b10, 300, "t2_ack1", n);
    @(negedge clk);
    check("t2_third", gnt, 2'b01);
    req = 2'b00;
    @(negedge clk);
    check("t2_abort0_ack", ack, 2'b01);
    check("t2_abort0_busy", busy, 1'b0);

    // Abort during fade in at level 5
    @(negedge clk); req = 2'b01;
    @(negedge clk);
    wait_pwm(5, 100, "t3_at5", n);
    req = 2'b00;
    @(negedge clk);
    check("t3_fo_level", pwm_control, 5);
    wait_ack(2'b01, 100, "t3_ack", n);
    check("t3_fall_cycles", n, 20);

    // Data change during hold is ignored
    @(negedge clk); req = 2'b01;
    @(negedge clk);
    wait_pwm(16, 200, "t4_hold", n);
    data0 = 16'hFFFF; dp0 = 4'b1111;
    @(negedge clk);
    check("t4_hex_hold", {hex3, hex2, hex1, hex0}, 16'h1234);
    wait_ack(2'b01, 200, "t4_ack", n);
    req = 2'b00;
    @(negedge clk);
    check("t4_hex_idle", {hex3, hex2, hex1, hex0}, 16'h1234);
    req = 2'b01;
    @(negedge clk);
    check("t4_new_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);

    // Reset mid-hold
    wait_pwm(16, 200, "t5_hold", n);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t5_rst_gnt", gnt, 2'b00);
    check("t5_rst_pwm", pwm_control, 0);
    check("t5_rst_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
    check("t5_rst_busy_ack", {busy, ack, dp_out}, 0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    check("t5_regrant", gnt, 2'b01);
    check("t5_regrant_hex", {hex3, hex2, hex1, hex0}, 16'hFFFF);
    req = 2'b00;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_display_arbiter.md
SSEG_DISPLAY_ARBITER -- requirements
Module: sseg_display_arbiter

Interface
REQ-001 Parameter PWM_RESOLUTION, default 4: brightness width; full-on level MAX = 2^PWM_RESOLUTION.
REQ-002 Parameter STEP_CYCLES, default 1_000_000: clock cycles per brightness step (step tick period).
REQ-003 Parameter HOLD_STEPS, default 64: number of step ticks spent at full brightness.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  2  per-requester display request, level-sensitive; bit i belongs to requester i.
REQ-007 data0, data1  in  16 each  requester digit values, nibble k drives digit k (k=0 rightmost).
REQ-008 dp0, dp1  in  4 each  requester decimal-point values, bit k for digit k.
REQ-009 gnt  out  2  one-hot grant; high for the whole service of requester i.
REQ-010 ack  out  2  one-cycle completion pulse to requester i.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 hex0..hex3  out  4 each  digit values for the display multiplexer.
REQ-013 dp_out  out  4  decimal-point values for the display multiplexer.
REQ-014 pwm_control  out  PWM_RESOLUTION+1  brightness level, 0 (dark) to MAX (full on).

Function
REQ-015 States: IDLE, FADE_IN, HOLD, FADE_OUT; all outputs are registered.
REQ-016 Step tick: an internal counter SHALL count 0..STEP_CYCLES-1, assert tick at STEP_CYCLES-1, wrap to 0, and clear to 0 on every state transition.
REQ-017 IDLE: pwm_control = 0, gnt = 0; if any req bit is high, on the next edge the arbiter SHALL grant one requester, enter FADE_IN, and latch that requester's data/dp into hex0..hex3/dp_out.
REQ-018 Arbitration SHALL be round-robin: when both req bits are high, grant the requester not served last; after reset requester 0 has priority.
REQ-019 FADE_IN: on each tick pwm_control increments by 1; the tick that makes it MAX moves the state to HOLD.
REQ-020 HOLD: pwm_control = MAX; after HOLD_STEPS ticks the state moves to FADE_OUT.
REQ-021 FADE_OUT: on each tick pwm_control decrements by 1; on the tick that makes it 0 the state moves to IDLE, gnt clears, and ack[i] is high for exactly that one cycle.
REQ-022 pwm_control SHALL never exceed MAX or wrap below 0.
REQ-023 Abort: if the granted requester's req drops during FADE_IN or HOLD, the next edge SHALL enter FADE_OUT from the current level; ack still pulses at completion.
REQ-024 A req drop during FADE_OUT SHALL NOT change behaviour; the fade completes normally.
REQ-025 Abort at level 0 (first FADE_IN step not yet taken) SHALL go to IDLE with ack on the next edge.
REQ-026 data/dp changes during service SHALL be ignored; latched values hold through IDLE until the next grant.
REQ-027 The state SHALL spend at least one cycle in IDLE between services; a pending req is granted on the edge after ack.
REQ-028 The non-granted requester's req is never dropped by the arbiter; it waits while high.

Reset
REQ-029 While reset_n = 0: state IDLE, gnt = 0, ack = 0, busy = 0, pwm_control = 0, hex0..hex3 = 0, dp_out = 0, tick counter = 0, and last-served = requester 1.
REQ-030 Reset asserted mid-service SHALL take effect immediately (asynchronous), with no ack generated.

Verification (STEP_CYCLES=4, HOLD_STEPS=2, PWM_RESOLUTION=4, MAX=16)
REQ-031 req=01 held, data0=16'h1234 -> gnt=01 one edge later, hex3..0=1,2,3,4; pwm reaches 16 at 64 cycles; HOLD lasts 8 cycles; pwm reaches 0 and ack[0] pulses 136 cycles after grant.
REQ-032 req=11 after reset -> requester 0 served first; requester 1 granted on the edge after ack[0]; a third service with both still high goes to requester 0.
REQ-033 req[0] dropped when pwm=5 in FADE_IN -> FADE_OUT from 5; ack[0] pulses 20 cycles later at pwm=0.
REQ-034 data0 changed to 16'hFFFF during HOLD -> hex outputs keep 1,2,3,4 until the next grant.
REQ-035 reset_n pulsed low during HOLD -> all outputs zero immediately; no ack; a new req is granted normally after release.
